disc_layer_scheduler: RTL and testbench
=======================================

Name: disc_layer_scheduler

Overview:
- Schedules and shares the three-layer discriminator datapath (layer1 256->128, layer2, layer3 -> scalar score, all Q8.8) between two requesters: the real-sample source and the generator (fake) source.
- Grants one sample per pass and latches its 256-element vector onto the discriminator input bus.
- Sequences each layer's start/done handshake, guards each wait with a watchdog, and returns the final score tagged with its source.

Parameters:
- DATA_W, 16, element width (Q8.8 signed)
- N_IN, 256, elements per sample vector
- TIMEOUT, 4096, max cycles allowed per layer wait before abort
- TO_W, 13, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_real  in  1  level request from real-sample source; held until grant_real
- req_fake  in  1  level request from generator; held until grant_fake
- real_data_flat  in  DATA_W*N_IN  real sample; element k at [(k+1)*16-1 -: 16]
- fake_data_flat  in  DATA_W*N_IN  generator sample; same packing
- disc_input_flat  out  DATA_W*N_IN  latched sample driving layer1
- grant_real  out  1  one-cycle grant pulse
- grant_fake  out  1  one-cycle grant pulse
- l1_start, l2_start, l3_start  out  1 each  one-cycle start pulses
- l1_done, l2_done, l3_done  in  1 each  layer completion (level or pulse)
- l3_score  in  DATA_W  layer3 output, valid while l3_done=1
- score_out  out  DATA_W  latched final score
- score_valid  out  1  one-cycle pulse; score_out and score_src are valid
- score_src  out  1  0=real, 1=fake
- score_is_real  out  1  1 when score_out > 0 (signed)
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky abort flag
- timeout_stage  out  2  layer that timed out (1..3); 0 when none

Behaviour:
- Reset: all outputs 0, disc_input_flat 0, state IDLE, last_src=1 so real wins the first tie, watchdog cleared.
- Reset mid-pass: state returns to IDLE at that edge; no start/grant/valid pulse is emitted afterwards.
- States and transitions:
  - IDLE -> GRANT when any request is high.
  - GRANT -> L1_WAIT. l1_start=1 in GRANT.
  - L1_WAIT -> L2_START on l1_done.
  - L2_START -> L2_WAIT. l2_start=1 in L2_START.
  - L2_WAIT -> L3_START on l2_done.
  - L3_START -> L3_WAIT. l3_start=1 in L3_START.
  - L3_WAIT -> RESULT on l3_done.
  - RESULT -> IDLE. score_valid=1 in RESULT.
- Arbitration:
  - Evaluated only in IDLE.
  - Single request: granted.
  - Both requesting: grant the source not equal to last_src (round-robin).
  - On grant: last_src updated; selected vector copied into disc_input_flat; that source's grant pulse is high during the GRANT cycle.
  - The source must drop its request after seeing the grant.
- disc_input_flat changes only at the IDLE->GRANT edge and holds through the pass.
- done inputs are sampled only in their own WAIT state; done seen in any other state is ignored.
- Score path:
  - At the L3_WAIT edge with l3_done=1: score_out<=l3_score, score_src<=granted source, score_is_real<=(l3_score!=0 && !l3_score[15]).
  - score_out, score_src and score_is_real hold until the next result.
- Latency with done returned the cycle after start:
  - Grant in cycle G; score_valid in G+6; IDLE in G+7.
  - Earliest next grant G+8. A request already high at G+7 is granted in G+8.
- Watchdog:
  - Cleared on entering each WAIT; increments each WAIT cycle with done=0.
  - If counter==TIMEOUT-1 and done=0 at an edge: go to IDLE, set timeout_err=1 and timeout_stage=1/2/3; no score_valid.
  - done and timeout at the same edge: done wins.
  - timeout_err and timeout_stage clear at the next GRANT.
- A request arriving while busy is held by the requester and not lost. No preemption.

Test Plan:
- Reset, req_real=1 with vector element k=k, done tied to start delayed by 1 -> grant_real pulse; disc_input_flat[31:16]=0x0001; l1/l2/l3_start pulses spaced 2 cycles apart; score_valid at G+6 with score_src=0.
- req_real and req_fake both high at the same edge after reset, both re-asserted after their grants -> grants alternate real, fake, real; score_src sequence 0,1,0.
- l3_score=0x0180 -> score_out=0x0180, score_is_real=1; l3_score=0xFF00 -> score_is_real=0; l3_score=0x0000 -> score_is_real=0.
- l2_done never asserted, TIMEOUT=16 -> abort to IDLE exactly 16 cycles after entering L2_WAIT; timeout_err=1, timeout_stage=2, no l3_start, no score_valid. Next grant clears both flags.
- l1_done pulsed during L2_START and during IDLE -> ignored, no state skip. done on the same edge as the watchdog limit -> pass continues, no error.
- rst asserted for 1 cycle during L3_WAIT -> all outputs 0 next cycle; a later l3_done gives no score_valid; a new request is granted normally afterwards.

Source files
------------

// File: rtl/disc_layer_scheduler.sv
// disc_layer_scheduler
// Shares one three-layer discriminator datapath (layer1 -> layer2 -> layer3,
// Q8.8) between a real-sample source and a generator source. One sample is
// granted per pass. Its vector is latched onto the discriminator input bus.
// Each layer is started in turn, with a watchdog on every done wait. The final
// score is returned tagged with the source that produced it.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   req_real, req_fake            level requests, held until the matching grant
//   real_data_flat/fake_data_flat candidate vectors, element k at [(k+1)*DATA_W-1 -: DATA_W]
//   disc_input_flat               vector latched at grant, held through the pass
//   grant_real, grant_fake        one-cycle grant pulses (GRANT state)
//   l1/l2/l3_start, l1/l2/l3_done per-layer handshake
//   l3_score                      layer3 output, valid while l3_done=1
//   score_out, score_src          latched result and its source (0=real, 1=fake)
//   score_is_real                 result strictly positive (signed)
//   score_valid                   one-cycle pulse when a new result is available
//   busy                          high outside IDLE
//   timeout_err, timeout_stage    sticky watchdog abort flag and failing layer (1..3)
module disc_layer_scheduler #(
  parameter int DATA_W  = 16,
  parameter int N_IN    = 256,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_real,
  input  logic                   req_fake,
  input  logic [DATA_W*N_IN-1:0] real_data_flat,
  input  logic [DATA_W*N_IN-1:0] fake_data_flat,
  output logic [DATA_W*N_IN-1:0] disc_input_flat,
  output logic                   grant_real,
  output logic                   grant_fake,
  output logic                   l1_start,
  output logic                   l2_start,
  output logic                   l3_start,
  input  logic                   l1_done,
  input  logic                   l2_done,
  input  logic                   l3_done,
  input  logic [DATA_W-1:0]      l3_score,
  output logic [DATA_W-1:0]      score_out,
  output logic                   score_valid,
  output logic                   score_src,
  output logic                   score_is_real,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [1:0]             timeout_stage
);

  typedef enum logic [2:0] {
    IDLE, GRANT, L1_WAIT, L2_START, L2_WAIT, L3_START, L3_WAIT, RESULT
  } state_t;

  state_t            state_reg, state_next;
  logic              src_reg;       // source owning the current pass
  logic              last_src_reg;  // last granted source, for round-robin ties
  logic [TO_W-1:0]   wdog_reg;
  logic              in_wait;
  logic              done_sel;      // done input belonging to the current WAIT state
  logic [1:0]        stage_code;
  logic              wdog_hit;
  logic              pick_fake;

  always_comb begin
    state_next = state_reg;
    grant_real = 1'b0;
    grant_fake = 1'b0;
    l1_start   = 1'b0;
    l2_start   = 1'b0;
    l3_start   = 1'b0;
    score_valid = 1'b0;
    in_wait    = 1'b0;
    done_sel   = 1'b0;
    stage_code = 2'd0;
    // Tie goes to whichever source was not served last.
    pick_fake  = req_fake && (!req_real || !last_src_reg);

    case (state_reg)
      IDLE:     if (req_real || req_fake) state_next = GRANT;
      GRANT: begin
        grant_real = !src_reg;
        grant_fake = src_reg;
        l1_start   = 1'b1;
        state_next = L1_WAIT;
      end
      L1_WAIT: begin
        in_wait = 1'b1; done_sel = l1_done; stage_code = 2'd1;
        if (l1_done) state_next = L2_START;
      end
      L2_START: begin
        l2_start   = 1'b1;
        state_next = L2_WAIT;
      end
      L2_WAIT: begin
        in_wait = 1'b1; done_sel = l2_done; stage_code = 2'd2;
        if (l2_done) state_next = L3_START;
      end
      L3_START: begin
        l3_start   = 1'b1;
        state_next = L3_WAIT;
      end
      L3_WAIT: begin
        in_wait = 1'b1; done_sel = l3_done; stage_code = 2'd3;
        if (l3_done) state_next = RESULT;
      end
      RESULT: begin
        score_valid = 1'b1;
        state_next  = IDLE;
      end
      default:  state_next = IDLE;
    endcase

    // Abort only when done is absent, so a done on the limit edge still wins.
    wdog_hit = in_wait && !done_sel && (wdog_reg == TO_W'(TIMEOUT - 1));
    if (wdog_hit) state_next = IDLE;

    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      src_reg         <= 1'b0;
      last_src_reg    <= 1'b1;
      wdog_reg        <= '0;
      disc_input_flat <= '0;
      score_out       <= '0;
      score_src       <= 1'b0;
      score_is_real   <= 1'b0;
      timeout_err     <= 1'b0;
      timeout_stage   <= 2'd0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE && (req_real || req_fake)) begin
        src_reg         <= pick_fake;
        last_src_reg    <= pick_fake;
        disc_input_flat <= pick_fake ? fake_data_flat : real_data_flat;
        timeout_err     <= 1'b0;
        timeout_stage   <= 2'd0;
      end

      // Counter is zero on the first cycle of every WAIT state.
      if (in_wait && !done_sel) wdog_reg <= wdog_reg + 1'b1;
      else                      wdog_reg <= '0;

      if (wdog_hit) begin
        timeout_err   <= 1'b1;
        timeout_stage <= stage_code;
      end

      if (state_reg == L3_WAIT && l3_done) begin
        score_out     <= l3_score;
        score_src     <= src_reg;
        score_is_real <= (l3_score != '0) && !l3_score[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_disc_layer_scheduler.sv
// Directed bench for disc_layer_scheduler with a scoreboard of expected results.
module tb_disc_layer_scheduler;

  localparam int DW  = 16;
  localparam int NI  = 256;
  localparam int TO  = 16;

  logic              clk, rst, req_real, req_fake;
  logic [DW*NI-1:0]  real_data_flat, fake_data_flat, disc_input_flat;
  logic              grant_real, grant_fake, l1_start, l2_start, l3_start;
  logic              l1_done, l2_done, l3_done;
  logic [DW-1:0]     l3_score, score_out;
  logic              score_valid, score_src, score_is_real, busy, timeout_err;
  logic [1:0]        timeout_stage;

  disc_layer_scheduler #(.DATA_W(DW), .N_IN(NI), .TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .req_real(req_real), .req_fake(req_fake),
    .real_data_flat(real_data_flat), .fake_data_flat(fake_data_flat),
    .disc_input_flat(disc_input_flat), .grant_real(grant_real), .grant_fake(grant_fake),
    .l1_start(l1_start), .l2_start(l2_start), .l3_start(l3_start),
    .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done), .l3_score(l3_score),
    .score_out(score_out), .score_valid(score_valid), .score_src(score_src),
    .score_is_real(score_is_real), .busy(busy), .timeout_err(timeout_err),
    .timeout_stage(timeout_stage)
  );

  typedef struct packed {
    logic          src;
    logic [DW-1:0] score;
    logic          is_real;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic [2:0] auto_en;   // per-layer automatic done responder enable

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // Returns done the cycle after each start pulse when enabled for that layer.
  initial begin
    logic p1, p2, p3;
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_en[0]) l1_done = p1;
      if (auto_en[1]) l2_done = p2;
      if (auto_en[2]) l3_done = p3;
      p1 = l1_start; p2 = l2_start; p3 = l3_start;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic src, input logic [DW-1:0] sc);
    exp_t e;
    e.src     = src;
    e.score   = sc;
    e.is_real = ($signed(sc) > 0);
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("score_out", 32'(score_out), 32'(e.score));
      chk("score_src", 32'(score_src), 32'(e.src));
      chk("score_is_real", 32'(score_is_real), 32'(e.is_real));
    end
  endtask

  task automatic wait_grant(output int n, output bit got);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (grant_real || grant_fake) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'd1);
  endtask

  // Runs one full pass with auto-responding layers, checking pulse timing.
  task automatic do_pass(input logic exp_src, input logic [DW-1:0] sc,
                         input bit rearm, input int exp_wait);
    int n;
    bit got;
    l3_score = sc;
    push_exp(exp_src, sc);
    wait_grant(n, got);
    if (!got) begin
      void'(sb.pop_front());
      return;
    end
    chk("grant_latency", 32'(n), 32'(exp_wait));
    chk("grant_real", 32'(grant_real), 32'(!exp_src));
    chk("grant_fake", 32'(grant_fake), 32'(exp_src));
    chk("l1_start_at_grant", 32'(l1_start), 32'd1);
    chk("busy_at_grant", 32'(busy), 32'd1);
    chk("timeout_err_cleared", 32'(timeout_err), 32'd0);
    chk("timeout_stage_cleared", 32'(timeout_stage), 32'd0);
    chk("disc_elem1", 32'(disc_input_flat[31:16]), exp_src ? 32'h1001 : 32'h0001);
    chk("disc_elem255", 32'(disc_input_flat[DW*NI-1 -: 16]), exp_src ? 32'h10FF : 32'h00FF);
    if (exp_src) req_fake = 1'b0; else req_real = 1'b0;
    for (int off = 1; off <= 7; off++) begin
      @(negedge clk);
      if (off == 1 && rearm) begin
        if (exp_src) req_fake = 1'b1; else req_real = 1'b1;
      end
      chk($sformatf("l2_start_off%0d", off), 32'(l2_start), 32'(off == 2));
      chk($sformatf("l3_start_off%0d", off), 32'(l3_start), 32'(off == 4));
      chk($sformatf("score_valid_off%0d", off), 32'(score_valid), 32'(off == 6));
      if (score_valid) pop_cmp();
      if (off == 7) chk("idle_after_pass", 32'(busy), 32'd0);
    end
    $display("pass src=%0d score=%h score_out=%h is_real=%0d", exp_src, sc, score_out, score_is_real);
  endtask

  initial begin
    int n;
    bit got;
    rst = 1'b1; req_real = 1'b0; req_fake = 1'b0;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    l3_score = '0; auto_en = 3'b111;
    for (int k = 0; k < NI; k++) begin
      real_data_flat[(k+1)*DW-1 -: DW] = DW'(k);
      fake_data_flat[(k+1)*DW-1 -: DW] = DW'(16'h1000 + k);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grants", 32'({grant_real, grant_fake}), 32'd0);
    chk("rst_starts", 32'({l1_start, l2_start, l3_start}), 32'd0);
    chk("rst_score_valid", 32'(score_valid), 32'd0);
    chk("rst_timeout", 32'({timeout_err, timeout_stage}), 32'd0);
    chk("rst_score_out", 32'(score_out), 32'd0);
    chk("rst_disc_input", 32'(disc_input_flat[31:0]), 32'd0);
    $display("reset checked");
    rst = 1'b0;
    @(negedge clk);

    // Single real request, latency check
    req_real = 1'b1;
    do_pass(1'b0, 16'h0100, 1'b0, 1);

    // Round-robin after a fresh reset: real, fake, real
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_real = 1'b1; req_fake = 1'b1;
    do_pass(1'b0, 16'h0200, 1'b1, 1);
    do_pass(1'b1, 16'h0300, 1'b0, 1);
    do_pass(1'b0, 16'h0400, 1'b0, 1);

    // Score sign cases
    req_real = 1'b1; do_pass(1'b0, 16'h0180, 1'b0, 1);
    req_real = 1'b1; do_pass(1'b0, 16'hFF00, 1'b0, 1);
    req_real = 1'b1; do_pass(1'b0, 16'h0000, 1'b0, 1);

    // Layer2 watchdog abort
    auto_en = 3'b101; l2_done = 1'b0;
    req_fake = 1'b1;
    wait_grant(n, got);
    chk("to_grant_fake", 32'(grant_fake), 32'd1);
    req_fake = 1'b0;
    for (int off = 1; off <= 19; off++) begin
      @(negedge clk);
      chk($sformatf("to_no_l3_start_off%0d", off), 32'(l3_start), 32'd0);
      chk($sformatf("to_no_valid_off%0d", off), 32'(score_valid), 32'd0);
      if (off == 2)  chk("to_l2_start", 32'(l2_start), 32'd1);
      if (off == 18) chk("to_busy_before", 32'({busy, timeout_err}), 32'b10);
      if (off == 19) begin
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_stage", 32'(timeout_stage), 32'd2);
      end
    end
    @(negedge clk);
    chk("to_err_sticky", 32'({timeout_err, timeout_stage}), 32'b110);
    $display("timeout err=%0d stage=%0d", timeout_err, timeout_stage);
    auto_en = 3'b111;
    req_real = 1'b1;
    do_pass(1'b0, 16'h0050, 1'b0, 1);

    // Stray done pulses ignored; done on the watchdog limit edge wins
    auto_en = 3'b000;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    @(negedge clk);
    l1_done = 1'b1;
    @(negedge clk);
    l1_done = 1'b0;
    chk("stray_idle_busy", 32'(busy), 32'd0);
    chk("stray_idle_grant", 32'({grant_real, grant_fake}), 32'd0);
    req_real = 1'b1;
    l3_score = 16'h0123;
    push_exp(1'b0, 16'h0123);
    wait_grant(n, got);
    req_real = 1'b0;
    for (int off = 1; off <= 22; off++) begin
      @(negedge clk);
      if (off == 1) l1_done = 1'b1;
      if (off == 2) chk("man_l2_start", 32'(l2_start), 32'd1);
      if (off == 3) l1_done = 1'b0;
      if (off >= 3 && off <= 18) chk($sformatf("no_skip_off%0d", off), 32'({l3_start, busy}), 32'b01);
      if (off == 18) l2_done = 1'b1;
      if (off == 19) begin
        l2_done = 1'b0;
        chk("limit_done_l3_start", 32'(l3_start), 32'd1);
        chk("limit_done_no_err", 32'(timeout_err), 32'd0);
      end
      if (off == 20) l3_done = 1'b1;
      if (off == 21) begin
        l3_done = 1'b0;
        chk("man_score_valid", 32'(score_valid), 32'd1);
        if (score_valid) pop_cmp();
      end
      if (off == 22) chk("man_idle", 32'({busy, timeout_err}), 32'd0);
    end
    $display("manual pass score_out=%h err=%0d", score_out, timeout_err);

    // Reset during L3_WAIT
    auto_en = 3'b011;
    l3_done = 1'b0;
    req_real = 1'b1;
    wait_grant(n, got);
    req_real = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pulses", 32'({grant_real, grant_fake, l1_start, l2_start, l3_start, score_valid}), 32'd0);
    chk("mid_rst_score", 32'({score_out, score_src, score_is_real}), 32'd0);
    chk("mid_rst_timeout", 32'({timeout_err, timeout_stage}), 32'd0);
    chk("mid_rst_disc", 32'(disc_input_flat[31:0]), 32'd0);
    rst = 1'b0;
    l3_done = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_quiet%0d", c), 32'({score_valid, busy, l1_start}), 32'd0);
    end
    l3_done = 1'b0;
    auto_en = 3'b111;
    $display("mid-pass reset recovered");
    req_real = 1'b1;
    do_pass(1'b0, 16'h0777, 1'b0, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
